// File: rtl/sig_watchdog.sv
// Rising-edge monitor for the upstream level indicator: counts edges, measures
// the interval between consecutive edges and flags a lost signal after TMAX idle cycles.
module sig_watchdog #(
  parameter int TMAX  = 25010,
  parameter int CBITS = 15,
  parameter int EBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  output logic             edge_pulse,
  output logic [CBITS-1:0] period,
  output logic             period_valid,
  output logic [EBITS-1:0] count,
  output logic             timeout
);

  typedef enum logic [1:0] {WAIT, RUN, LOST} state_t;

  state_t           state, state_d;
  logic             sig_q;
  logic [CBITS-1:0] timer;
  logic [CBITS:0]   timer_p1;
  logic [CBITS-1:0] timer_sat;
  logic             edge_det;
  logic             expire;
  logic             timeout_d;

  assign edge_det  = sig & ~sig_q;
  assign timer_p1  = {1'b0, timer} + (CBITS+1)'(1);
  assign timer_sat = (&timer) ? timer : timer_p1[CBITS-1:0];
  assign expire    = timer_p1 >= (CBITS+1)'(TMAX);

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT;
    else     state <= state_d;
  end

  // An edge always wins over a coincident expiry.
  always_comb begin
    state_d = state;
    case (state)
      WAIT, RUN: begin
        if (edge_det)    state_d = RUN;
        else if (expire) state_d = LOST;
      end
      LOST:    if (edge_det) state_d = RUN;
      default: state_d = WAIT;
    endcase
  end

  always_comb begin
    timeout_d = (state_d == LOST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q        <= 1'b0;
      timer        <= '0;
      edge_pulse   <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      count        <= '0;
      timeout      <= 1'b0;
    end else begin
      sig_q      <= sig;
      edge_pulse <= edge_det;
      timeout    <= timeout_d;
      if (edge_det) begin
        count <= count + EBITS'(1);
        timer <= '0;
        // The first edge after reset only starts the measurement.
        if (state != WAIT) begin
          period       <= timer_sat;
          period_valid <= 1'b1;
        end
      end else begin
        timer <= timer_sat;
      end
    end
  end

endmodule

// File: tb/tb_sig_watchdog.sv
// Scoreboard bench for sig_watchdog: an event-count model queues expected
// outputs per driven cycle; they are checked just after the sampling posedge.
module tb_sig_watchdog;

  localparam int TMAX  = 20;
  localparam int CBITS = 6;
  localparam int EBITS = 8;
  localparam int PMAX  = (1 << CBITS) - 1;

  logic             clk;
  logic             rst;
  logic             sig;
  logic             edge_pulse;
  logic [CBITS-1:0] period;
  logic             period_valid;
  logic [EBITS-1:0] count;
  logic             timeout;

  sig_watchdog #(.TMAX(TMAX), .CBITS(CBITS), .EBITS(EBITS)) dut (
    .clk(clk), .rst(rst), .sig(sig),
    .edge_pulse(edge_pulse), .period(period), .period_valid(period_valid),
    .count(count), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pulse;
    int per;
    int pv;
    int cnt;
    int to;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // model: cycles since last edge (unbounded), whether any edge seen since reset
  int m_prev, m_since, m_seen, m_lost, m_pulse, m_per, m_pv, m_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input int s, input int r);
    exp_t e;
    if (r != 0) begin
      m_prev = 0; m_since = 0; m_seen = 0; m_lost = 0;
      m_pulse = 0; m_per = 0; m_pv = 0; m_cnt = 0;
    end else if (s != 0 && m_prev == 0) begin
      m_prev  = 1;
      m_pulse = 1;
      m_cnt   = (m_cnt + 1) % (1 << EBITS);
      if (m_seen != 0) begin
        m_per = (m_since + 1 > PMAX) ? PMAX : m_since + 1;
        m_pv  = 1;
      end
      m_seen  = 1;
      m_since = 0;
      m_lost  = 0;
    end else begin
      m_prev  = s;
      m_pulse = 0;
      m_since++;
      if (m_since >= TMAX) m_lost = 1;
    end
    e.pulse = m_pulse; e.per = m_per; e.pv = m_pv; e.cnt = m_cnt; e.to = m_lost;
    q.push_back(e);
  endtask

  task automatic step(input int s, input int r);
    exp_t e;
    @(negedge clk);
    sig = (s != 0);
    rst = (r != 0);
    model(s, r);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: queue empty at %0t", $time);
    end else begin
      e = q.pop_front();
      chk("edge_pulse",   32'(edge_pulse),   e.pulse);
      chk("period",       32'(period),       e.per);
      chk("period_valid", 32'(period_valid), e.pv);
      chk("count",        32'(count),        e.cnt);
      chk("timeout",      32'(timeout),      e.to);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  task automatic do_reset();
    step(0, 1);
    step(0, 1);
  endtask

  task automatic edges(input int n, input int space, input int width);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < space; j++) step((j < width) ? 1 : 0, 0);
  endtask

  initial begin
    sig = 1'b0;
    rst = 1'b1;
    m_prev = 0; m_since = 0; m_seen = 0; m_lost = 0;
    m_pulse = 0; m_per = 0; m_pv = 0; m_cnt = 0;

    // reset then silence: timeout exactly TMAX cycles after release
    do_reset();
    idle(25);
    chk("timeout_after_idle", 32'(timeout), 1);

    // 2-wide pulses every 12 cycles
    do_reset();
    edges(6, 12, 2);
    chk("period_12", 32'(period), 12);

    // spacing == TMAX never times out; spacing TMAX+1 does, for one cycle
    do_reset();
    edges(4, 20, 1);
    edges(3, 21, 1);
    chk("period_21", 32'(period), 21);

    // sig held high: single edge, then timeout, no measurement
    do_reset();
    for (int i = 0; i < 100; i++) step(1, 0);
    chk("held_count", 32'(count), 1);
    chk("held_pv", 32'(period_valid), 0);

    // long gap saturates period, then wrap the edge counter
    do_reset();
    step(1, 0);
    idle(69);
    step(1, 0);
    chk("period_sat", 32'(period), PMAX);
    step(0, 0);
    edges(256, 2, 1);
    chk("count_wrap", 32'(count), 2);

    // reset mid-RUN with timer=15, count=5
    do_reset();
    edges(5, 10, 1);
    idle(6);
    step(0, 1);
    chk("mid_rst_count", 32'(count), 0);
    step(1, 0);
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_pv", 32'(period_valid), 0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sig_watchdog.md
# sig_watchdog

Downstream monitor for the level-reached indicator `sig` produced by the load/store volume stage. It detects rising edges of `sig`, counts them, and measures the interval between consecutive edges. It raises a sticky-until-recovery `timeout` when no edge arrives within `TMAX` cycles. This gives the benchmark a concrete observable for the property "the stage keeps reaching full level", checked as a bounded-response safety property rather than a liveness one.

## Interface
- `TMAX`, 25010: maximum allowed cycles between edges (and from reset to first edge); must satisfy 2 ≤ `TMAX` < 2^`CBITS`.
- `CBITS`, 15: width of interval timer and `period`.
- `EBITS`, 8: width of edge counter.
- `clk`  input  1  clock; all state updates on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `sig`  input  1  monitored level indicator from the upstream stage.
- `edge_pulse`  output  1  one-cycle strobe per detected rising edge.
- `period`  output  CBITS  cycles between the last two rising edges, saturating.
- `period_valid`  output  1  `period` holds a real measurement.
- `count`  output  EBITS  number of rising edges since reset, wraps mod 2^`EBITS`.
- `timeout`  output  1  high while in LOST state.

## Operation
- Internal registers: `sig_q` (previous `sig`), `timer` (CBITS), `state` ∈ {WAIT, RUN, LOST}.
- Reset, applied at a posedge with `rst`=1: `state`=WAIT, `sig_q`=0, `timer`=0, `edge_pulse`=0, `period`=0, `period_valid`=0, `count`=0, `timeout`=0. Reset overrides all other activity, including mid-measurement.
- Edge definition: at a posedge, `edge` = `sig` & ~`sig_q`. `sig_q` <= `sig` every non-reset cycle.
  - Because `sig_q` resets to 0, `sig`=1 at the first posedge after reset counts as an edge.
  - `sig` held high produces only one edge.
- Every non-reset posedge: `edge_pulse` <= `edge`.
- On edge:
  - `count` <= `count`+1 (wraps).
  - `timer` <= 0.
  - `state` <= RUN.
  - `timeout` <= 0.
  - If the prior state is RUN or LOST: `period` <= min(`timer`+1, 2^CBITS−1) and `period_valid` <= 1.
  - If the prior state is WAIT: `period` and `period_valid` are unchanged.
- No edge:
  - `timer` <= min(`timer`+1, 2^CBITS−1).
  - If in WAIT or RUN and `timer`+1 ≥ `TMAX`: `state` <= LOST and `timeout` <= 1.
  - LOST persists, with `timer` still saturating, until the next edge.
- Transitions:
  - WAIT→RUN on edge; WAIT→LOST on expiry.
  - RUN→RUN on edge; RUN→LOST on expiry.
  - LOST→RUN on edge.
- Simultaneous edge and expiry at the same posedge: the edge wins; state RUN, `timeout` stays 0.
- `period_valid` is sticky; it clears only on reset.

## Timing
- All outputs are registered. Latency from `sig` first sampled high to `edge_pulse`, `count` and `period` updating is 1 cycle: they are visible after the same posedge that samples the edge.
- Edges at posedges k and k+P give `period`=P after posedge k+P.
- Last edge at posedge k with none after: `timeout` rises after posedge k+`TMAX`.
  - An edge at posedge k+`TMAX` prevents it.
  - From reset released at posedge r (first non-reset posedge r+1): `timeout` rises after posedge r+`TMAX`.
- `timeout` falls after the posedge that samples the recovering edge, coincident with `edge_pulse`=1.

## Test plan
- Reset release with `sig`=0, params `TMAX`=20, `CBITS`=6 → all outputs 0; `timeout` rises exactly 20 cycles after reset release, state LOST.
- Rising edges every 12 cycles, each pulse 2 cycles wide → `edge_pulse` high 1 cycle per edge; `count` 1,2,3…; `period`=12 with `period_valid`=1 from the second edge; `timeout` never asserts.
- Edges spaced exactly 20 (=`TMAX`) apart → no timeout (edge wins tie); spacing 21 → `timeout`=1 for 1 cycle, cleared with the next `edge_pulse`, and `period`=21.
- `sig` held high for 100 cycles from the first post-reset posedge, with `TMAX`=20 → exactly one edge (`count`=1); `timeout` after 20 cycles; `period_valid` stays 0.
- Gap of 70 cycles with `CBITS`=6 → `period` saturates at 63; `count` wraps 255→0 after 256 edges with `EBITS`=8.
- `rst` asserted mid-RUN with `timer`=15, `count`=5 → next cycle all outputs 0 and state WAIT; `sig` high at the first posedge after release → `count`=1, `period_valid`=0.
